// File: rtl/bcd_pkg.sv
// Shared BCD conversion definitions: FSM states, default geometry and digit type.
// Also used by bin2bcd_ext.
package bcd_pkg;

  localparam int BCD_DIGITS = 8;
  localparam int BIN_W      = 27;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_OP    = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic is_bad_digit(input digit_t d);
    return (d > 4'd9);
  endfunction

endpackage

// File: rtl/bcd2bin_ext_if.sv
// Request/result bundle for the BCD-to-binary converter.
interface bcd2bin_ext_if #(
  parameter int BCD_DIGITS = bcd_pkg::BCD_DIGITS,
  parameter int BIN_W      = bcd_pkg::BIN_W
);
  logic             start;
  bcd_pkg::digit_t  bcd [BCD_DIGITS-1:0];
  logic [2:0]       dp;
  logic             ready;
  logic             done;
  logic [BIN_W-1:0] bin;
  logic             err;

  modport master (output start, bcd, dp, input ready, done, bin, err);
  modport slave  (input start, bcd, dp, output ready, done, bin, err);
endinterface

// File: rtl/bcd2bin_ext_sub3.sv
// Per-digit correction for reverse double-dabble: subtract 3 from values of 8 or more.
module bcd_digit_sub3
  import bcd_pkg::digit_t;
(
  input  digit_t i_d,
  output digit_t o_d
);
  assign o_d = (i_d >= 4'd8) ? (i_d - 4'd3) : i_d;
endmodule

// File: rtl/bcd2bin_ext.sv
// Sequential BCD-to-binary converter with decimal scaling (reverse double-dabble).
// Low dp digits are dropped first, then BIN_W shift/correct iterations build the result.
module bcd2bin_ext
  import bcd_pkg::digit_t, bcd_pkg::state_t, bcd_pkg::is_bad_digit;
  import bcd_pkg::S_IDLE, bcd_pkg::S_ALIGN, bcd_pkg::S_OP, bcd_pkg::S_DONE;
#(
  parameter int BCD_DIGITS = bcd_pkg::BCD_DIGITS,
  parameter int BIN_W      = bcd_pkg::BIN_W
)(
  input  logic          clk,
  input  logic          rst_n,
  bcd2bin_ext_if.slave  bus
);
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  digit_t           r_dig [BCD_DIGITS-1:0];
  digit_t           w_shift [BCD_DIGITS-1:0];
  digit_t           w_adj [BCD_DIGITS-1:0];
  logic [BIN_W-1:0] r_bin_sr;
  logic [BIN_W-1:0] w_bin_sr_nxt;
  logic [2:0]       r_dp_cnt;
  logic [CNT_W-1:0] r_it_cnt;
  logic [BIN_W-1:0] r_bin;
  logic             r_err;
  logic             w_inv;

  // Digits below the decimal scale are discarded, so they never flag an error
  always_comb begin
    w_inv = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if ((i >= int'(bus.dp)) && is_bad_digit(bus.bcd[i])) begin
        w_inv = 1'b1;
      end else begin
        w_inv = w_inv;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_dig
      if (gi == BCD_DIGITS - 1) begin : g_top
        assign w_shift[gi] = {1'b0, r_dig[gi][3:1]};
      end else begin : g_mid
        assign w_shift[gi] = {r_dig[gi+1][0], r_dig[gi][3:1]};
      end
      bcd_digit_sub3 u_sub3 (.i_d(w_shift[gi]), .o_d(w_adj[gi]));
    end
  endgenerate

  assign w_bin_sr_nxt = {r_dig[0][0], r_bin_sr[BIN_W-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!bus.start)            w_state_nxt = S_IDLE;
        else if (w_inv)            w_state_nxt = S_DONE;
        else if (bus.dp != 3'd0)   w_state_nxt = S_ALIGN;
        else                       w_state_nxt = S_OP;
      end
      S_ALIGN: begin
        if (r_dp_cnt == 3'd1) w_state_nxt = S_OP;
        else                  w_state_nxt = S_ALIGN;
      end
      S_OP: begin
        if (r_it_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
        else                       w_state_nxt = S_OP;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath; the result is captured on the last OP edge so it is valid with done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BCD_DIGITS; i++) r_dig[i] <= 4'd0;
      r_bin_sr <= '0;
      r_dp_cnt <= 3'd0;
      r_it_cnt <= '0;
      r_bin    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && w_inv) begin
            r_bin <= '0;
            r_err <= 1'b1;
          end else if (bus.start) begin
            for (int i = 0; i < BCD_DIGITS; i++) r_dig[i] <= bus.bcd[i];
            r_dp_cnt <= bus.dp;
            r_it_cnt <= CNT_W'(BIN_W);
            r_bin_sr <= '0;
            r_err    <= 1'b0;
          end
        end
        S_ALIGN: begin
          for (int i = 0; i < BCD_DIGITS - 1; i++) r_dig[i] <= r_dig[i+1];
          r_dig[BCD_DIGITS-1] <= 4'd0;
          r_dp_cnt <= r_dp_cnt - 3'd1;
        end
        S_OP: begin
          for (int i = 0; i < BCD_DIGITS; i++) r_dig[i] <= w_adj[i];
          r_bin_sr <= w_bin_sr_nxt;
          r_it_cnt <= r_it_cnt - CNT_W'(1);
          if (r_it_cnt == CNT_W'(1)) r_bin <= w_bin_sr_nxt;
        end
        S_DONE:  ;
        default: ;
      endcase
    end
  end

  assign bus.ready = (r_state == S_IDLE);
  assign bus.done  = (r_state == S_DONE);
  assign bus.bin   = r_bin;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_bcd2bin_ext.sv
// Scoreboard bench for bcd2bin_ext: directed vectors push expectations, a monitor
// pops and checks value, error flag and latency on every done pulse.
module tb_bcd2bin_ext;

  typedef struct {
    int   bin;
    logic err;
    int   lat;
    int   t0;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb [$];

  bcd2bin_ext_if u_if ();

  bcd2bin_ext dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst_n && u_if.done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bin", int'(u_if.bin), e.bin);
        chk("err", int'(u_if.err), int'(e.err));
        chk("latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic drive(input logic [31:0] v, input logic [2:0] d);
    for (int i = 0; i < 8; i++) u_if.bcd[i] = v[4*i +: 4];
    u_if.dp = d;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 200 && !u_if.ready; k++) begin
      @(posedge clk); #1;
    end
    chk("ready_before_start", int'(u_if.ready), 1);
  endtask

  task automatic issue(input logic [31:0] v, input logic [2:0] d,
                       input int exp_bin, input logic exp_err, input int lat);
    wait_ready();
    drive(v, d);
    u_if.start = 1'b1;
    sb.push_back('{exp_bin, exp_err, lat, cyc});
    @(posedge clk); #1;
    u_if.start = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 200 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    u_if.start = 1'b0;
    drive(32'h0000_0000, 3'd0);
    #12;
    chk("rst_ready", int'(u_if.ready), 1);
    chk("rst_done",  int'(u_if.done),  0);
    chk("rst_bin",   int'(u_if.bin),   0);
    chk("rst_err",   int'(u_if.err),   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'h1234_5678, 3'd0, 12345678, 1'b0, 28);
    drain();
    issue(32'h9999_9999, 3'd0, 99999999, 1'b0, 28);
    drain();
    issue(32'h0000_0000, 3'd0, 0, 1'b0, 28);
    drain();
    issue(32'h1234_5678, 3'd3, 12345, 1'b0, 31);
    drain();
    issue(32'h1234_5678, 3'd7, 1, 1'b0, 35);
    drain();
    issue(32'h1234_A678, 3'd0, 0, 1'b1, 1);
    drain();
    issue(32'h1234_A678, 3'd4, 1234, 1'b0, 32);
    drain();
    issue(32'h0000_0999, 3'd2, 9, 1'b0, 30);
    drain();

    // start held high across a conversion while bcd changes
    wait_ready();
    drive(32'h0000_0005, 3'd0);
    u_if.start = 1'b1;
    sb.push_back('{5, 1'b0, 28, cyc});
    repeat (3) begin @(posedge clk); #1; end
    drive(32'h0000_0007, 3'd0);
    chk("ready_busy", int'(u_if.ready), 0);
    repeat (10) begin @(posedge clk); #1; end
    chk("ready_busy_late", int'(u_if.ready), 0);
    for (int k = 0; k < 100 && !u_if.ready; k++) begin
      @(posedge clk); #1;
    end
    chk("ready_after_done", int'(u_if.ready), 1);
    sb.push_back('{7, 1'b0, 28, cyc});
    @(posedge clk); #1;
    u_if.start = 1'b0;
    drain();

    // reset during OP aborts without a done pulse
    issue(32'h1234_5678, 3'd0, 0, 1'b0, 0);
    void'(sb.pop_back());
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    chk("abort_ready", int'(u_if.ready), 1);
    chk("abort_done",  int'(u_if.done),  0);
    chk("abort_bin",   int'(u_if.bin),   0);
    chk("abort_err",   int'(u_if.err),   0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    issue(32'h0000_0042, 3'd0, 42, 1'b0, 28);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd2bin_ext.md
BCD2BIN_EXT -- requirements
Module: bcd2bin_ext

Interface
REQ-001 SHALL have parameter BCD_DIGITS, default 8: number of input BCD digits.
REQ-002 SHALL have parameter BIN_W, default 27: output width; 2^27 exceeds 99,999,999.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 start  input  1  conversion request; sampled only while ready=1.
REQ-006 bcd  input  4 x BCD_DIGITS (unpacked [3:0] bcd [7:0])  digit 0 least significant; sampled on start.
REQ-007 dp  input  3  decimal scale; count of low digits discarded before conversion; sampled on start.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 done  output  1  one-cycle pulse; bin and err valid.
REQ-010 bin  output  BIN_W  registered result; held until the next accepted start.
REQ-011 err  output  1  registered; invalid input digit detected; held with bin.

Function
REQ-012 SHALL implement FSM states IDLE, ALIGN, OP, DONE.
REQ-013 IDLE with start=1 and any digit >9: SHALL clear bin, set err=1, and go to DONE next cycle (done at cycle 1 after start).
REQ-014 IDLE with start=1 and all digits valid: SHALL load the digit register, dp counter=dp, iteration counter=BIN_W, clear the binary shift register and err, and go to ALIGN if dp!=0, else OP.
REQ-015 ALIGN: per cycle, digit[i]<=digit[i+1], top digit<=0, dp counter-1; SHALL go to OP when counter reaches 0.
REQ-016 OP: per cycle, shift {digits, binary} right one bit; then in each digit, a value >=8 SHALL be reduced by 3; iteration counter-1; SHALL go to DONE when it reaches 0.
REQ-017 DONE: done=1 for exactly one cycle; bin<=binary register unless err; SHALL go to IDLE next cycle.
REQ-018 Latency, start-cycle = 0: valid input gives done at cycle dp+BIN_W+1 (28 for dp=0); invalid input gives done at cycle 1.
REQ-019 start outside IDLE SHALL be ignored, with no effect on state or outputs.
REQ-020 Back-to-back: start asserted in the IDLE cycle after DONE SHALL be accepted.
REQ-021 dp=7 SHALL convert only the top digit; discarded digits SHALL never set err.
REQ-022 Result SHALL equal floor(decimal value / 10^dp), exact for all valid inputs; no overflow is possible.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, ready=1, done=0, bin=0, err=0, and all counters and shift registers to 0.
REQ-024 Reset during ALIGN or OP SHALL abort the conversion with no done pulse; the first start after release SHALL be converted normally.

Structure
REQ-025 A shared package bcd_pkg SHALL hold the state enum, BCD_DIGITS, BIN_W, and the digit type (logic [3:0]), which it shares with bin2bcd_ext.
REQ-026 One combinational sub-module bcd_digit_sub3 (4-bit in; out = in>=8 ? in-3 : in) SHALL be instantiated once per digit via generate.
REQ-027 All outputs SHALL be driven from registers or decoded state only, with no combinational path from inputs.

Verification
REQ-028 bcd=1,2,3,4,5,6,7,8 (MSD first), dp=0, start pulse -> done at cycle 28, bin=12345678 (0xBC614E), err=0.
REQ-029 bcd=99999999, dp=0 -> bin=0x5F5E0FF at cycle 28; bcd=00000000 -> bin=0 at cycle 28.
REQ-030 bcd=12345678, dp=3 -> done at cycle 31, bin=12345; dp=7 -> done at cycle 35, bin=1.
REQ-031 digit 3 = 0xA, dp=0 -> done at cycle 1, err=1, bin=0; same invalid digit with dp=4 -> converts, err=0.
REQ-032 start held high through a conversion with changing bcd -> the first sample only is converted; ready=0 until after done; the second start is accepted in the following IDLE cycle.
REQ-033 rst_n pulsed low in OP cycle 10 -> outputs zero immediately, no done pulse; a new start of 00000042 -> bin=42 at cycle 28.
